// File: rtl/calc_sequencer_if.sv
// Instruction handshake bundle between an instruction source and the
// calculator sequencer.
interface calc_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_src;
  logic [1:0] instr_dst;
  logic [3:0] instr_imm;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_src,
    output instr_dst,
    output instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_src,
    input  instr_dst,
    input  instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/calc_sequencer.sv
// Multi-cycle READ/EXEC/WB controller driving the 4x4 register file
// and the 4-bit combinational ALU, one instruction per four cycles.
module calc_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_sequencer_if.slave  instr,
  output logic [1:0]       rf_rd_addr,
  input  logic [3:0]       rf_rd_data,
  output logic             rf_we,
  output logic [1:0]       rf_we_addr,
  output logic [3:0]       rf_we_data,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_control,
  input  logic [3:0]       alu_res,
  output logic             done,
  output logic [3:0]       result,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [2:0] OP_ILL = 3'b011;

  logic [1:0]       state_q;
  logic [2:0]       op_q;
  logic [1:0]       src_q;
  logic [1:0]       dst_q;
  logic [3:0]       imm_q;
  logic [3:0]       opa_q;
  logic [3:0]       res_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr.instr_valid) begin
            if (instr.instr_op == OP_ILL) begin
              err_q <= 1'b1;
            end else begin
              op_q    <= instr.instr_op;
              src_q   <= instr.instr_src;
              dst_q   <= instr.instr_dst;
              imm_q   <= instr.instr_imm;
              state_q <= READ;
            end
          end
        end
        READ: begin
          opa_q   <= rf_rd_data;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_res;
          state_q <= WB;
        end
        WB: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from state and latched fields only
  assign instr.instr_ready = (state_q == IDLE);
  assign rf_we       = (state_q == WB);
  assign done        = (state_q == WB);
  assign err         = err_q;
  assign rf_rd_addr  = src_q;
  assign rf_we_addr  = dst_q;
  assign rf_we_data  = res_q;
  assign result      = res_q;
  assign alu_a       = opa_q;
  assign alu_b       = imm_q;
  assign alu_control = op_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with behavioural register file
// and ALU models attached.
module tb_calc_sequencer;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rf_rd_addr;
  logic [3:0]    rf_rd_data;
  logic          rf_we;
  logic [1:0]    rf_we_addr;
  logic [3:0]    rf_we_data;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_control;
  logic [3:0]    alu_res;
  logic          done;
  logic [3:0]    result;
  logic          err;
  logic [CW-1:0] instr_count;

  calc_sequencer_if ifc ();

  calc_sequencer #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (ifc.slave),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .rf_we       (rf_we),
    .rf_we_addr  (rf_we_addr),
    .rf_we_data  (rf_we_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_res     (alu_res),
    .done        (done),
    .result      (result),
    .err         (err),
    .instr_count (instr_count)
  );

  logic [3:0] rf [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  always @(negedge clk)
    if (rf_we) rf[rf_we_addr] <= rf_we_data;

  assign rf_rd_data = rf[rf_rd_addr];

  function automatic logic [3:0] alu_f(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_control, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] imm;
    logic [3:0] res;
  } vec_t;

  int checks;
  int errors;
  int retired;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(retired);
  endfunction

  task automatic drive(input vec_t v);
    ifc.instr_op  = v.op;
    ifc.instr_src = v.src;
    ifc.instr_dst = v.dst;
    ifc.instr_imm = v.imm;
  endtask

  task automatic run_one(input vec_t v);
    int n = 0;
    while (!ifc.instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 32'(n < 20), 1);
    drive(v);
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    chk("read_busy", {ifc.instr_ready, rf_we, done}, 0);
    @(posedge clk); #1;
    chk("exec_we", {rf_we, done}, 0);
    chk("exec_alu_b", alu_b, v.imm);
    @(posedge clk); #1;
    chk("wb_we", {rf_we, done}, 3);
    chk("wb_addr", rf_we_addr, v.dst);
    chk("wb_data", rf_we_data, v.res);
    chk("wb_result", result, v.res);
    retired++;
    @(posedge clk); #1;
    chk("idle_state", {ifc.instr_ready, rf_we, done}, 4);
    chk("count", instr_count, exp_cnt());
    chk("rf_written", rf[v.dst], v.res);
  endtask

  vec_t tv [8];
  vec_t bq [3];
  vec_t v;

  initial begin
    checks  = 0;
    errors  = 0;
    retired = 0;
    // Starting from all-zero registers; each row depends on the previous
    tv[0] = '{3'b010, 2'd0, 2'd1, 4'h5, 4'h5};
    tv[1] = '{3'b110, 2'd1, 2'd2, 4'h7, 4'hE};
    tv[2] = '{3'b111, 2'd2, 2'd3, 4'h1, 4'h1};
    tv[3] = '{3'b000, 2'd1, 2'd0, 4'h6, 4'h4};
    tv[4] = '{3'b001, 2'd3, 2'd3, 4'h8, 4'h9};
    tv[5] = '{3'b100, 2'd2, 2'd1, 4'h6, 4'h8};
    tv[6] = '{3'b101, 2'd0, 2'd2, 4'hF, 4'h4};
    tv[7] = '{3'b111, 2'd1, 2'd0, 4'h3, 4'h1};
    bq[0] = '{3'b110, 2'd3, 2'd0, 4'h1, 4'h2};
    bq[1] = '{3'b010, 2'd0, 2'd0, 4'h4, 4'h6};
    bq[2] = '{3'b001, 2'd0, 2'd2, 4'h8, 4'hE};

    rst_n           = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.instr_op    = '0;
    ifc.instr_src   = '0;
    ifc.instr_dst   = '0;
    ifc.instr_imm   = '0;
    #12;
    chk("rst_ready", ifc.instr_ready, 1);
    chk("rst_flags", {rf_we, done, err}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_one(tv[i]);

    // Illegal opcode: rejected with a single err pulse
    v = '{3'b011, 2'd2, 2'd2, 4'h3, 4'h0};
    drive(v);
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_ready", ifc.instr_ready, 1);
    chk("ill_we", rf_we, 0);
    @(posedge clk); #1;
    chk("ill_err_drop", err, 0);
    chk("ill_count", instr_count, exp_cnt());
    chk("ill_rf", rf[2], 4'h4);
    run_one('{3'b010, 2'd0, 2'd3, 4'h2, 4'h3});

    // Back-to-back: valid held high across three instructions
    begin
      int ai = 0;
      int ri = 0;
      int cyc = 0;
      int last = -1;
      int busy = 0;
      bit rp;
      drive(bq[0]);
      ifc.instr_valid = 1'b1;
      rp = ifc.instr_ready;
      while (ri < 3 && cyc < 40) begin
        @(posedge clk); #1; cyc++;
        if (rp && ifc.instr_valid) begin
          if (last >= 0) chk("b2b_gap", cyc - last, 4);
          last = cyc;
          ai++;
          if (ai < 3) drive(bq[ai]);
          else ifc.instr_valid = 1'b0;
        end
        if (done) begin
          chk("b2b_res", result, bq[ri].res);
          chk("b2b_addr", rf_we_addr, bq[ri].dst);
          ri++;
          retired++;
        end
        if (!ifc.instr_ready) busy++;
        rp = ifc.instr_ready;
      end
      ifc.instr_valid = 1'b0;
      chk("b2b_retired", ri, 3);
      chk("b2b_busy", busy, 9);
      @(posedge clk); #1;
      chk("b2b_count", instr_count, exp_cnt());
      chk("b2b_r0", rf[0], 4'h6);
      chk("b2b_r2", rf[2], 4'hE);
    end

    // Reset asserted while the instruction sits in EXEC
    drive('{3'b010, 2'd1, 2'd1, 4'h1, 4'h9});
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_exec_we", rf_we, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ifc.instr_ready, 1);
    chk("mid_rst_flags", {rf_we, done, err}, 0);
    chk("mid_rst_count", instr_count, 0);
    chk("mid_rst_data", {result, alu_a, alu_b}, 0);
    retired = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("mid_rst_rf", rf[1], 4'h8);
    run_one('{3'b010, 2'd1, 2'd1, 4'h1, 4'h9});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Multi-cycle controller that sequences the 4-bit calculator datapath: the 4x4 register file and the combinational ALU. It accepts one instruction at a time over a valid/ready handshake and steps it through READ, EXEC and WB. READ fetches the source register, EXEC runs the ALU with the immediate, and WB writes the result to the destination register. It sits between an instruction source (testbench or future fetch unit) and the existing register file and ALU, which it drives directly.

Parameters:
CNT_W, 8, width of retired-instruction counter instr_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on instr_* fields
instr_ready  output  1  sequencer can accept an instruction
instr_op  input  3  ALU control code: 000 AND, 001 OR, 010 SUM, 100 AND-NOT, 101 OR-NOT, 110 SUB, 111 SLT; 011 illegal
instr_src  input  2  source register index (operand A)
instr_dst  input  2  destination register index
instr_imm  input  4  immediate (operand B)
rf_rd_addr  output  2  register file read address
rf_rd_data  input  4  register file read data (combinational)
rf_we  output  1  register file write enable
rf_we_addr  output  2  register file write address
rf_we_data  output  4  register file write data
alu_a  output  4  ALU operand A
alu_b  output  4  ALU operand B
alu_control  output  3  ALU control code
alu_res  input  4  ALU result (combinational)
done  output  1  one-cycle pulse: instruction retired
result  output  4  value written by the retiring instruction
err  output  1  one-cycle pulse: illegal opcode rejected
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset state: FSM in IDLE. All registers and outputs are 0, except instr_ready, which is 1. rf_we must drop immediately on rst_n falling; it must not wait for a clock edge.
- Output style: Moore. Every output is a function of the state register and the latched registers only, with no combinational path from inputs to outputs.
- Latched fields: op_q, src_q, dst_q, imm_q are captured on accept.
  - rf_rd_addr = src_q, alu_b = imm_q, alu_control = op_q, rf_we_addr = dst_q.
  - alu_a = opa_q, rf_we_data = res_q, result = res_q.
  - All of these are driven continuously and hold their last value while idle.
- IDLE:
  - instr_ready = 1.
  - Accept happens on a posedge with instr_valid & instr_ready.
  - Legal op: latch the fields and go to READ.
  - instr_op == 011: latch nothing, assert err for exactly the next cycle, stay in IDLE with instr_ready = 1. No write occurs and instr_count is unchanged.
- READ: instr_ready = 0. At the next posedge, capture opa_q <= rf_rd_data, then go to EXEC.
- EXEC: ALU inputs are stable from opa_q, imm_q and op_q. At the next posedge, capture res_q <= alu_res, then go to WB.
- WB:
  - rf_we = 1 for exactly this one cycle. The register file writes on negedge clk, so the write lands mid-cycle.
  - done = 1 and result = res_q for the same cycle.
  - At the next posedge, instr_count increments and the FSM returns to IDLE.
- Latency: accept edge E0 → READ after E0 → EXEC after E1 → WB after E2 → IDLE after E3. Sustained throughput is 1 instruction per 4 cycles.
- Handshake:
  - instr_ready is low in READ, EXEC and WB.
  - The source must hold instr_valid and the fields stable until accepted.
  - A valid seen while busy is ignored, not queued.
- Hazards: a read-after-write to the same register is correct with no stall. The WB write completes at the negedge before the next instruction's READ.
- Counter: instr_count wraps from 2^CNT_W-1 to 0. Illegal ops are not counted.
- Width rules: all arithmetic is 4-bit and is performed by the ALU. The sequencer does no arithmetic except instr_count + 1.
- Reset mid-operation: the in-flight instruction is dropped. No write reaches the register file, and done and err are not asserted. After rst_n rises, the next instruction can be accepted at the first posedge.

Test Plan:
- Reset, then accept {op=010, src=0, dst=1, imm=5} with all registers 0 → rf_we is high only in the 4th cycle after accept, with we_addr=1 and we_data=0101; done pulses once with result=0101; instr_count=1.
- Next, {op=110, src=1, dst=2, imm=7} → R2=1110 (5-7), result=1110. Then {op=111, src=2, dst=3, imm=1} → R3=0001 (-2<1).
- Back-to-back: hold instr_valid high with 3 queued instructions → accepts are exactly 4 cycles apart; instr_ready is low in the 3 busy cycles; each instruction retires once and in order.
- Illegal op 011 → err pulses 1 cycle after accept; rf_we stays 0; instr_count unchanged; instr_ready stays 1; the next legal instruction executes normally.
- Deassert rst_n during EXEC → outputs drop to 0 asynchronously; rf_we is never asserted; the register file is unchanged; instr_count=0; instr_ready=1.
- Counter wrap with CNT_W=2: retire 5 legal instructions → instr_count sequence 1, 2, 3, 0, 1.
